// File: rtl/life_pkg.sv
// Shared types and index helpers for the Game-of-Life grid engine.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAUSE = 2'd1,
    RUN   = 2'd2,
    HALT  = 2'd3
  } state_e;

  // Flat bit index of cell (r,c) in a grid that is cols wide.
  function automatic int unsigned cell_idx(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned cols);
    return r * cols + c;
  endfunction

  // Wrap a possibly negative or overflowing coordinate into 0..n-1.
  function automatic int unsigned wrap_idx(input int i, input int unsigned n);
    int m;
    m = int'(n);
    return $unsigned(((i % m) + m) % m);
  endfunction

endpackage

// File: rtl/life_next_gen.sv
// Combinational next-generation evaluator: applies the Life rule to every cell.
module life_next_gen
  import life_pkg::*;
#(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned COLS  = 8,
  parameter int unsigned TORUS = 0
) (
  input  logic [ROWS*COLS-1:0] cur,
  output logic [ROWS*COLS-1:0] nxt
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned IDX_W = $clog2(N);

  // True when (rr,cc) lies inside the grid; neighbours outside are dead unless wrapping.
  function automatic logic in_grid(input int rr, input int cc);
    return (rr >= 0) && (rr < int'(ROWS)) && (cc >= 0) && (cc < int'(COLS));
  endfunction

  for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
    for (genvar c = 0; c < int'(COLS); c++) begin : g_col
      logic [3:0] cnt;

      // Count live neighbours of cell (r,c); index is always wrapped so it stays in range.
      always_comb begin
        cnt = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (((dr != 0) || (dc != 0)) && ((TORUS != 0) || in_grid(r + dr, c + dc))) begin
              cnt = cnt + 4'(cur[IDX_W'(cell_idx(wrap_idx(r + dr, ROWS),
                                                  wrap_idx(c + dc, COLS), COLS))]);
            end
          end
        end
      end

      assign nxt[r*COLS+c] = (cnt == 4'd3) || (cur[r*COLS+c] && (cnt == 4'd2));
    end
  end

endmodule

// File: rtl/life_grid_engine.sv
// Game-of-Life generation engine: seed load, run/step control, generation
// counter and stable/extinct status around a combinational next-gen core.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned TORUS    = 0,
  parameter int unsigned STEP_DIV = 1,
  parameter int unsigned GEN_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 load,
  input  logic                 run,
  input  logic                 step,
  output logic [ROWS*COLS-1:0] grid,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 stable,
  output logic                 extinct,
  output logic                 changed
);

  localparam int unsigned N        = ROWS * COLS;
  localparam int unsigned DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     grid_q, grid_d;
  logic [N-1:0]     next_grid;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             stable_q, stable_d;
  logic             changed_q, changed_d;
  logic             do_gen;

  life_next_gen #(
    .ROWS (ROWS),
    .COLS (COLS),
    .TORUS(TORUS)
  ) u_next_gen (
    .cur(grid_q),
    .nxt(next_grid)
  );

  // Control FSM: load has priority, then run, then step; a generation update
  // moves to HALT when nothing changed or everything died.
  always_comb begin
    state_d   = state_q;
    grid_d    = grid_q;
    gen_d     = gen_q;
    div_d     = div_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    do_gen    = 1'b0;

    if (load) begin
      grid_d   = seed;
      gen_d    = '0;
      stable_d = 1'b0;
      div_d    = '0;
      state_d  = run ? RUN : PAUSE;
    end else begin
      case (state_q)
        PAUSE: begin
          if (run) begin
            state_d = RUN;
            div_d   = '0;
          end else if (step) begin
            do_gen = 1'b1;
          end
        end
        RUN: begin
          if (!run) begin
            state_d = PAUSE;
          end else if (div_q == DIV_LAST) begin
            do_gen = 1'b1;
            div_d  = '0;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: ;
      endcase

      if (do_gen) begin
        grid_d    = next_grid;
        changed_d = 1'b1;
        gen_d     = (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
        stable_d  = (next_grid == grid_q);
        if ((next_grid == grid_q) || (next_grid == '0)) begin
          state_d = HALT;
        end
      end
    end
  end

  // State, grid and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grid_q    <= '0;
      gen_q     <= '0;
      div_q     <= '0;
      stable_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grid_q    <= grid_d;
      gen_q     <= gen_d;
      div_q     <= div_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
    end
  end

  assign grid      = grid_q;
  assign gen_count = gen_q;
  assign stable    = stable_q;
  assign changed   = changed_q;
  assign extinct   = (grid_q == '0);

endmodule

// File: tb/tb_life_grid_engine.sv
// Bench for life_grid_engine: three instances (plain, toroidal, divided rate),
// a scoreboard of expected (grid, gen_count) per generation update.
module tb_life_grid_engine;

  localparam logic [63:0] BLINK = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] VERT  = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK = 64'h0000_0000_0000_0303;
  localparam logic [63:0] WRAPV = 64'h0100_0000_0000_0101;

  typedef struct packed {
    logic [63:0] grid;
    logic [15:0] gen;
  } sb_t;

  logic        clk;
  logic        reset;
  logic [63:0] seed;
  logic        load_v [3];
  logic        run_v  [3];
  logic        step_v [3];
  logic [63:0] grid_o [3];
  logic [15:0] gen_o  [3];
  logic        stb_o  [3];
  logic        ext_o  [3];
  logic        chg_o  [3];

  sb_t sb_q[$];
  int  sel;
  int  total;
  int  bad;

  life_grid_engine #(.TORUS(0), .STEP_DIV(1)) dut0 (
    .clk(clk), .reset(reset), .seed(seed), .load(load_v[0]), .run(run_v[0]),
    .step(step_v[0]), .grid(grid_o[0]), .gen_count(gen_o[0]), .stable(stb_o[0]),
    .extinct(ext_o[0]), .changed(chg_o[0]));

  life_grid_engine #(.TORUS(1), .STEP_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .seed(seed), .load(load_v[1]), .run(run_v[1]),
    .step(step_v[1]), .grid(grid_o[1]), .gen_count(gen_o[1]), .stable(stb_o[1]),
    .extinct(ext_o[1]), .changed(chg_o[1]));

  life_grid_engine #(.TORUS(0), .STEP_DIV(4)) dut2 (
    .clk(clk), .reset(reset), .seed(seed), .load(load_v[2]), .run(run_v[2]),
    .step(step_v[2]), .grid(grid_o[2]), .gen_count(gen_o[2]), .stable(stb_o[2]),
    .extinct(ext_o[2]), .changed(chg_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every generation pulse on the selected instance must match the next expectation.
  always @(negedge clk) begin
    if (reset && chg_o[sel]) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected dut%0d: got grid=%h gen=%0d, no update expected",
                 sel, grid_o[sel], gen_o[sel]);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (grid_o[sel] !== e.grid || gen_o[sel] !== e.gen) begin
          bad++;
          $display("FAIL sb_update dut%0d: got grid=%h gen=%0d, want grid=%h gen=%0d",
                   sel, grid_o[sel], gen_o[sel], e.grid, e.gen);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tk();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] g, input logic [15:0] n);
    sb_t e;
    e.grid = g;
    e.gen  = n;
    sb_q.push_back(e);
  endtask

  task automatic do_load(input int d, input logic [63:0] s, input logic r);
    seed      = s;
    load_v[d] = 1'b1;
    run_v[d]  = r;
    tk();
    load_v[d] = 1'b0;
  endtask

  task automatic do_step(input int d);
    step_v[d] = 1'b1;
    tk();
    step_v[d] = 1'b0;
  endtask

  task automatic wait_sb(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tk();
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_timeout: got %0d pending updates, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    #3;
    total++; if (grid_o[0] !== 64'h0) begin bad++; $display("FAIL rst_grid: got %h want 0", grid_o[0]); end
    total++; if (gen_o[0] !== 16'd0) begin bad++; $display("FAIL rst_gen: got %0d want 0", gen_o[0]); end
    total++; if (stb_o[0] !== 1'b0) begin bad++; $display("FAIL rst_stable: got %b want 0", stb_o[0]); end
    total++; if (ext_o[0] !== 1'b1) begin bad++; $display("FAIL rst_extinct: got %b want 1", ext_o[0]); end
    total++; if (chg_o[0] !== 1'b0) begin bad++; $display("FAIL rst_changed: got %b want 0", chg_o[0]); end
    tk();
    reset = 1'b1;
    tk();
  endtask

  task automatic test_blinker();
    sel = 0;
    do_load(0, BLINK, 1'b0);
    total++; if (grid_o[0] !== BLINK) begin bad++; $display("FAIL blink_load: got %h want %h", grid_o[0], BLINK); end
    push(VERT, 16'd1);
    do_step(0);
    wait_sb(4);
    tk();
    total++; if (chg_o[0] !== 1'b0) begin bad++; $display("FAIL blink_pulse_width: got %b want 0", chg_o[0]); end
    push(BLINK, 16'd2);
    do_step(0);
    wait_sb(4);
    total++; if (stb_o[0] !== 1'b0) begin bad++; $display("FAIL blink_stable: got %b want 0", stb_o[0]); end
    total++; if (ext_o[0] !== 1'b0) begin bad++; $display("FAIL blink_extinct: got %b want 0", ext_o[0]); end
  endtask

  task automatic test_block();
    sel = 0;
    push(BLOCK, 16'd1);
    do_load(0, BLOCK, 1'b1);
    wait_sb(4);
    total++; if (stb_o[0] !== 1'b1) begin bad++; $display("FAIL block_stable: got %b want 1", stb_o[0]); end
    repeat (5) tk();
    total++; if (gen_o[0] !== 16'd1) begin bad++; $display("FAIL block_halt_gen: got %0d want 1", gen_o[0]); end
    total++; if (grid_o[0] !== BLOCK) begin bad++; $display("FAIL block_grid: got %h want %h", grid_o[0], BLOCK); end
    run_v[0] = 1'b0;
    tk();
  endtask

  task automatic test_single();
    sel = 0;
    do_load(0, 64'h1, 1'b0);
    push(64'h0, 16'd1);
    do_step(0);
    wait_sb(4);
    total++; if (ext_o[0] !== 1'b1) begin bad++; $display("FAIL single_extinct: got %b want 1", ext_o[0]); end
    do_step(0);
    tk();
    do_step(0);
    tk();
    total++; if (gen_o[0] !== 16'd1) begin bad++; $display("FAIL single_halt_gen: got %0d want 1", gen_o[0]); end
  endtask

  task automatic test_edge_wrap();
    sel = 1;
    do_load(1, 64'h83, 1'b0);
    push(WRAPV, 16'd1);
    do_step(1);
    wait_sb(4);
    total++; if (ext_o[1] !== 1'b0) begin bad++; $display("FAIL wrap_torus_extinct: got %b want 0", ext_o[1]); end
    sel = 0;
    do_load(0, 64'h83, 1'b0);
    push(64'h0, 16'd1);
    do_step(0);
    wait_sb(4);
    total++; if (ext_o[0] !== 1'b1) begin bad++; $display("FAIL wrap_flat_extinct: got %b want 1", ext_o[0]); end
  endtask

  task automatic test_divider();
    int first;
    int second;
    sel = 2;
    first = -1;
    second = -1;
    do_load(2, BLINK, 1'b1);
    push(VERT, 16'd1);
    push(BLINK, 16'd2);
    for (int k = 2; k <= 12; k++) begin
      tk();
      if (chg_o[2] === 1'b1) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    run_v[2] = 1'b0;
    total++; if (first != 5) begin bad++; $display("FAIL div_first_tick: got cycle %0d want 5", first); end
    total++; if (second - first != 4) begin bad++; $display("FAIL div_period: got %0d want 4", second - first); end
    wait_sb(2);
    // Step held high while running must be ignored; dropping run pauses.
    step_v[2] = 1'b1;
    do_load(2, BLINK, 1'b1);
    push(VERT, 16'd1);
    repeat (5) tk();
    run_v[2]  = 1'b0;
    step_v[2] = 1'b0;
    repeat (3) tk();
    total++; if (gen_o[2] !== 16'd1) begin bad++; $display("FAIL pause_gen: got %0d want 1", gen_o[2]); end
    total++; if (grid_o[2] !== VERT) begin bad++; $display("FAIL pause_grid: got %h want %h", grid_o[2], VERT); end
    push(BLINK, 16'd2);
    do_step(2);
    wait_sb(4);
    total++; if (gen_o[2] !== 16'd2) begin bad++; $display("FAIL pause_step_gen: got %0d want 2", gen_o[2]); end
  endtask

  task automatic test_reset_midrun();
    int n;
    sel = 0;
    do_load(0, BLINK, 1'b1);
    push(VERT, 16'd1);
    push(BLINK, 16'd2);
    push(VERT, 16'd3);
    n = 0;
    while (gen_o[0] !== 16'd3 && n < 10) begin
      tk();
      n++;
    end
    total++; if (gen_o[0] !== 16'd3) begin bad++; $display("FAIL midrun_reach: got gen %0d want 3", gen_o[0]); end
    #1;
    reset = 1'b0;
    #1;
    total++; if (grid_o[0] !== 64'h0) begin bad++; $display("FAIL midrun_rst_grid: got %h want 0", grid_o[0]); end
    total++; if (gen_o[0] !== 16'd0) begin bad++; $display("FAIL midrun_rst_gen: got %0d want 0", gen_o[0]); end
    total++; if (ext_o[0] !== 1'b1) begin bad++; $display("FAIL midrun_rst_extinct: got %b want 1", ext_o[0]); end
    total++; if (stb_o[0] !== 1'b0) begin bad++; $display("FAIL midrun_rst_stable: got %b want 0", stb_o[0]); end
    run_v[0] = 1'b0;
    wait_sb(1);
    tk();
    reset = 1'b1;
    tk();
    do_step(0);
    run_v[0] = 1'b1;
    repeat (3) tk();
    run_v[0] = 1'b0;
    tk();
    total++; if (gen_o[0] !== 16'd0) begin bad++; $display("FAIL idle_gen: got %0d want 0", gen_o[0]); end
    total++; if (grid_o[0] !== 64'h0) begin bad++; $display("FAIL idle_grid: got %h want 0", grid_o[0]); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sel   = 0;
    reset = 1'b0;
    seed  = '0;
    for (int i = 0; i < 3; i++) begin
      load_v[i] = 1'b0;
      run_v[i]  = 1'b0;
      step_v[i] = 1'b0;
    end
    test_reset();
    test_blinker();
    test_block();
    test_single();
    test_edge_wrap();
    test_divider();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
